afifo_wr_traffic_gen: RTL and testbench
=======================================

AFIFO_WR_TRAFFIC_GEN -- requirements
Module: afifo_wr_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default afifo_tb_pkg::DATA_WIDTH, the write data width (8, 16 or 32).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of the word-count and sent-count fields.
REQ-003 SHALL have port wclk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port wrst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle run request.
REQ-006 SHALL have port num_words, input, CNT_WIDTH, the number of writes in the run.
REQ-007 SHALL have port burst_len, input, 8, writes per burst; 0 means continuous.
REQ-008 SHALL have port gap_len, input, 8, idle cycles between bursts.
REQ-009 SHALL have port data_seed, input, DATA_WIDTH, the first data value of the run.
REQ-010 SHALL have port wfull, input, 1, the FIFO full flag, synchronous to wclk.
REQ-011 SHALL have port winc, output, 1, the FIFO write strobe.
REQ-012 SHALL have port wdata, output, DATA_WIDTH, the FIFO write data.
REQ-013 SHALL have port busy, output, 1, high while a run is active.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse at run completion.
REQ-015 SHALL have port sent_count, output, CNT_WIDTH, the writes accepted in the current or last run.

Function
REQ-016 SHALL implement FSM IDLE, BURST, GAP, DONE; a write is accepted at any wclk rising edge with winc=1.
REQ-017 IDLE: busy=0, winc=0. On start with num_words!=0, SHALL latch num_words, burst_len and gap_len, load wdata=data_seed, clear sent_count, and enter BURST on the next edge.
REQ-018 IDLE: start with num_words==0 SHALL go to DONE without writing; sent_count SHALL be 0.
REQ-019 start while busy=1 SHALL be ignored, with no change to latched values.
REQ-020 BURST: winc SHALL be combinational !wfull; wfull=1 SHALL stall with no counter or data change.
REQ-021 Each accepted write SHALL advance wdata to the next pattern value, increment sent_count, decrement remaining, and increment the burst count.
REQ-022 The accepted write that makes remaining=0 SHALL take the FSM to DONE; this takes priority over burst end.
REQ-023 If the burst count reaches burst_len (burst_len!=0) and gap_len!=0, SHALL go to GAP and clear the burst count; if gap_len==0, SHALL clear the burst count and stay in BURST.
REQ-024 GAP: winc=0 for exactly gap_len cycles, then SHALL return to BURST.
REQ-025 DONE: done=1 for one cycle, busy=0, then SHALL return to IDLE; sent_count SHALL hold until the next start.
REQ-026 Default pattern: wdata SHALL increment by 1 modulo 2^DATA_WIDTH, wrapping from all-ones to 0.
REQ-027 winc SHALL never be 1 while wfull=1.

Reset
REQ-028 wrst_n=0 SHALL asynchronously force IDLE with winc=0, wdata=0, busy=0, done=0, sent_count=0, and all internal counters at 0.
REQ-029 Reset mid-run SHALL abandon the run without a done pulse; operation resumes at the first edge after deassertion.

Configuration
REQ-030 With macro AFIFO_WR_LFSR_EN defined, wdata SHALL follow a maximal-length Fibonacci LFSR seeded from data_seed, with a seed of 0 replaced by 1.
REQ-031 Without AFIFO_WR_LFSR_EN, SHALL use the incrementing pattern of REQ-026 and contain no LFSR logic.

Structure
REQ-032 afifo_tb_pkg SHALL hold the FSM state enum typedef and the LFSR tap constants for widths 8, 16 and 32.
REQ-033 SHALL instantiate one sub-module, afifo_wr_pattern_gen, with ports load, seed, advance and value, containing the counter/LFSR under the macro.

Verification
REQ-034 start, num_words=5, burst_len=0, data_seed=8'h10, wfull=0 -> winc high 5 consecutive cycles, wdata 10..14, done 1 cycle after the last write, sent_count=5.
REQ-035 num_words=6, burst_len=2, gap_len=3 -> write pattern WW---WW---WW then done; no gap after the final burst.
REQ-036 wfull=1 for 4 cycles mid-burst -> winc=0 and wdata held during the stall; total 8 writes for num_words=8, none lost or duplicated.
REQ-037 data_seed=8'hFE, num_words=4 -> wdata FE, FF, 00, 01; with AFIFO_WR_LFSR_EN and seed 0 -> first word 8'h01, no repeat within 255 writes.
REQ-038 wrst_n pulsed low after 3 of 10 writes -> winc=0 immediately, no done, sent_count=0; a new start with num_words=2 completes normally.
REQ-039 start with num_words=0 -> done 1 cycle later, no winc; a second start while busy -> ignored.

Source files
------------

// File: rtl/afifo_tb_pkg.sv
// -----------------------------------------------------------------------------
// afifo_tb_pkg
// Shared definitions for the asynchronous-FIFO write traffic generator:
//   - DATA_WIDTH    : default write-data width used by the generator
//   - wr_state_e    : write-side FSM state encoding
//   - LFSR_TAPS_*   : Fibonacci LFSR feedback masks (maximal length) for
//                     8, 16 and 32 bit data, used when AFIFO_WR_LFSR_EN is set
//   - lfsr_taps()   : selects the mask for a given width
// -----------------------------------------------------------------------------
package afifo_tb_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // Feedback masks: x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1, x^32+x^22+x^2+x+1
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return {24'h00_0000, LFSR_TAPS_8};
      16:      return {16'h0000, LFSR_TAPS_16};
      32:      return LFSR_TAPS_32;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/afifo_wr_pattern_gen.sv
// -----------------------------------------------------------------------------
// afifo_wr_pattern_gen
// Holds the current write-data word and steps it to the next pattern value.
// Default build: value increments by one and wraps modulo 2^DATA_WIDTH.
// With macro AFIFO_WR_LFSR_EN: value is a maximal-length Fibonacci LFSR; a
// zero seed is replaced by 1 so the register never locks up.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (value -> 0)
//   load, seed : load the seed as the first word of a run (wins over advance)
//   advance    : step to the next pattern value
//   value      : current word
// -----------------------------------------------------------------------------
module afifo_wr_pattern_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] value
);

  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] value_d;
  logic [DATA_WIDTH-1:0] seed_init_s;
  logic [DATA_WIDTH-1:0] next_s;

`ifdef AFIFO_WR_LFSR_EN
  import afifo_tb_pkg::*;
  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  // LFSR seed fix-up and next state (shift left, XOR of tapped bits into bit 0)
  always_comb begin
    if (seed == {DATA_WIDTH{1'b0}}) begin
      seed_init_s = DATA_WIDTH'(1);
    end else begin
      seed_init_s = seed;
    end
    next_s = {value_q[DATA_WIDTH-2:0], ^(value_q & TAPS)};
  end
`else
  // Incrementing pattern: seed used as-is, natural wrap from all-ones to zero
  always_comb begin
    seed_init_s = seed;
    next_s      = value_q + DATA_WIDTH'(1);
  end
`endif

  // Next-value selection
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed_init_s;
    end else if (advance) begin
      value_d = next_s;
    end else begin
      value_d = value_q;
    end
  end

  // Pattern register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= {DATA_WIDTH{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/afifo_wr_traffic_gen.sv
// -----------------------------------------------------------------------------
// afifo_wr_traffic_gen
// Write-side traffic generator for an asynchronous FIFO. A one-cycle start
// launches a run of num_words writes, issued in bursts of burst_len writes
// (0 = continuous) separated by gap_len idle cycles. Writes stall while wfull
// is high; done pulses for one cycle after the final write.
// Optional feature: define AFIFO_WR_LFSR_EN to use an LFSR data pattern
// instead of the default incrementing pattern.
// Ports:
//   wclk, wrst_n : clock, asynchronous active-low reset
//   start        : run request (ignored while busy)
//   num_words    : writes in the run
//   burst_len    : writes per burst, 0 = continuous
//   gap_len      : idle cycles between bursts
//   data_seed    : first data word of the run
//   wfull        : FIFO full flag (wclk domain)
//   winc, wdata  : FIFO write strobe and data
//   busy, done   : run active, one-cycle completion pulse
//   sent_count   : writes accepted in the current or last run
// -----------------------------------------------------------------------------
module afifo_wr_traffic_gen #(
  parameter int DATA_WIDTH = afifo_tb_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [7:0]            burst_len,
  input  logic [7:0]            gap_len,
  input  logic [DATA_WIDTH-1:0] data_seed,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sent_count
);
  import afifo_tb_pkg::*;

  wr_state_e            state_q,     state_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0] sent_q,      sent_d;
  logic [7:0]           burst_len_q, burst_len_d;
  logic [7:0]           gap_len_q,   gap_len_d;
  logic [7:0]           burst_cnt_q, burst_cnt_d;
  logic [7:0]           gap_cnt_q,   gap_cnt_d;
  logic                 load_s;
  logic                 advance_s;
  logic                 winc_s;

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    burst_len_d = burst_len_q;
    gap_len_d   = gap_len_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    load_s      = 1'b0;
    advance_s   = 1'b0;
    winc_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sent_d = {CNT_WIDTH{1'b0}};
          if (num_words != {CNT_WIDTH{1'b0}}) begin
            remaining_d = num_words;
            burst_len_d = burst_len;
            gap_len_d   = gap_len;
            burst_cnt_d = 8'd0;
            gap_cnt_d   = 8'd0;
            load_s      = 1'b1;
            state_d     = ST_BURST;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BURST: begin
        // Write strobe is combinational so a full FIFO is never written
        winc_s = ~wfull;
        if (!wfull) begin
          advance_s   = 1'b1;
          sent_d      = sent_q + CNT_WIDTH'(1);
          remaining_d = remaining_q - CNT_WIDTH'(1);
          // Final write ends the run even if it also closes a burst
          if (remaining_q == CNT_WIDTH'(1)) begin
            burst_cnt_d = 8'd0;
            state_d     = ST_DONE;
          end else if ((burst_len_q != 8'd0) && (burst_cnt_q == burst_len_q - 8'd1)) begin
            burst_cnt_d = 8'd0;
            if (gap_len_q != 8'd0) begin
              gap_cnt_d = 8'd0;
              state_d   = ST_GAP;
            end else begin
              state_d = ST_BURST;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_BURST;
        end
      end

      ST_GAP: begin
        // gap_cnt counts 0..gap_len-1, giving exactly gap_len idle cycles
        if (gap_cnt_q == gap_len_q - 8'd1) begin
          gap_cnt_d = 8'd0;
          state_d   = ST_BURST;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= {CNT_WIDTH{1'b0}};
      sent_q      <= {CNT_WIDTH{1'b0}};
      burst_len_q <= 8'd0;
      gap_len_q   <= 8'd0;
      burst_cnt_q <= 8'd0;
      gap_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
      burst_len_q <= burst_len_d;
      gap_len_q   <= gap_len_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  afifo_wr_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pattern (
    .clk     (wclk),
    .rst_n   (wrst_n),
    .load    (load_s),
    .seed    (data_seed),
    .advance (advance_s),
    .value   (wdata)
  );

  assign winc       = winc_s;
  assign busy       = (state_q == ST_BURST) || (state_q == ST_GAP);
  assign done       = (state_q == ST_DONE);
  assign sent_count = sent_q;

endmodule

// File: tb/tb_afifo_wr_traffic_gen.sv
// -----------------------------------------------------------------------------
// tb_afifo_wr_traffic_gen
// Scoreboard bench: each run pushes its expected data words, expected
// completion count and (when the FIFO never fills) the expected per-cycle
// write timeline into queues; a monitor process pops and compares whenever
// the DUT writes or signals done.
// -----------------------------------------------------------------------------
module tb_afifo_wr_traffic_gen;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [7:0]    burst_len = 8'd0;
  logic [7:0]    gap_len = 8'd0;
  logic [DW-1:0] data_seed = '0;
  logic          wfull = 1'b0;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_count;

  int total = 0;
  int bad   = 0;
  int full_mode = 0;
  int ph = 0;

  logic [DW-1:0] exp_data[$];
  int            exp_done[$];
  bit            exp_winc[$];

  always #5 wclk = ~wclk;

  afifo_wr_traffic_gen #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .start      (start),
    .num_words  (num_words),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .data_seed  (data_seed),
    .wfull      (wfull),
    .winc       (winc),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference pattern: first word and successor, from the pattern definition
  function automatic logic [DW-1:0] first_word(input logic [DW-1:0] s);
`ifdef AFIFO_WR_LFSR_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [DW-1:0] next_word(input logic [DW-1:0] v);
`ifdef AFIFO_WR_LFSR_EN
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
    return DW'((int'(v) + 1) % 256);
`endif
  endfunction

  task automatic monitor();
    forever begin
      @(negedge wclk);
      if (wrst_n) begin
        if (winc) begin
          check("winc_while_full", wfull, 0);
          check("write_expected", (exp_data.size() > 0) ? 1 : 0, 1);
          if (exp_data.size() > 0) check("wdata", wdata, exp_data.pop_front());
        end
        if (done) begin
          check("done_expected", (exp_done.size() > 0) ? 1 : 0, 1);
          if (exp_done.size() > 0) check("done_sent_count", sent_count, exp_done.pop_front());
        end
        if (exp_winc.size() > 0) check("winc_timeline", winc, exp_winc.pop_front());
      end
    end
  endtask

  task automatic full_driver();
    forever begin
      @(posedge wclk);
      #2;
      if (start) ph = 0; else ph++;
      case (full_mode)
        1:       wfull = ($urandom_range(0, 2) == 0);
        2:       wfull = (ph >= 2 && ph < 6);
        default: wfull = 1'b0;
      endcase
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge wclk);
      if (done) seen = 1'b1;
    end
    check("done_timeout", seen, 1);
    @(posedge wclk);
    #1;
  endtask

  task automatic run(input int n, input int bl, input int gl, input int seed,
                     input int mode, input bit wait_for_done);
    logic [DW-1:0] v;
    int cnt;
    @(posedge wclk);
    #1;
    full_mode = mode;
    start     = 1'b1;
    num_words = CW'(n);
    burst_len = 8'(bl);
    gap_len   = 8'(gl);
    data_seed = DW'(seed);
    v = first_word(DW'(seed));
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(v);
      v = next_word(v);
    end
    exp_done.push_back(n);
    if (mode == 0) begin
      exp_winc.push_back(1'b0);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
        exp_winc.push_back(1'b1);
        cnt++;
        if (i != n - 1 && bl != 0 && (cnt % bl) == 0)
          for (int g = 0; g < gl; g++) exp_winc.push_back(1'b0);
      end
      exp_winc.push_back(1'b0);
    end
    @(posedge wclk);
    #1;
    start = 1'b0;
    if (wait_for_done) wait_done();
  endtask

  initial begin
    int writes;
    fork
      monitor();
      full_driver();
    join_none

    // Reset state
    #12;
    check("rst_winc", winc, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent_count", sent_count, 0);
    wrst_n = 1'b1;

    // Continuous run, 5 words from 0x10
    run(5, 0, 0, 'h10, 0, 1);
    check("sent_count_hold", sent_count, 5);

    // Bursts of 2 with 3-cycle gaps; a start while busy must be ignored
    run(6, 2, 3, 'h20, 0, 0);
    repeat (2) @(posedge wclk);
    #1;
    check("busy_midrun", busy, 1);
    start = 1'b1; num_words = CW'(1); data_seed = 8'hAA; burst_len = 8'd0;
    @(posedge wclk);
    #1;
    start = 1'b0;
    wait_done();

    // Four-cycle stall mid-burst
    run(8, 0, 0, 'h30, 2, 1);
    check("stall_sent_count", sent_count, 8);

    // Data wrap
    run(4, 0, 0, 'hFE, 0, 1);

    // Zero-length run: done one cycle after start, no writes
    run(0, 0, 0, 'h55, 0, 0);
    @(negedge wclk);
    check("zero_run_done", done, 1);
    check("zero_run_winc", winc, 0);
    @(posedge wclk);
    #1;

    // Reset after 3 of 10 writes
    run(10, 0, 0, 'h40, 3, 0);
    writes = 0;
    for (int k = 0; k < 50 && writes < 3; k++) begin
      @(negedge wclk);
      if (winc) writes++;
    end
    check("pre_reset_writes", writes, 3);
    @(posedge wclk);
    #1;
    wrst_n = 1'b0;
    exp_data.delete();
    exp_done.delete();
    exp_winc.delete();
    #1;
    check("midrun_rst_winc", winc, 0);
    check("midrun_rst_sent_count", sent_count, 0);
    check("midrun_rst_busy", busy, 0);
    @(negedge wclk);
    check("midrun_rst_done", done, 0);
    #2;
    wrst_n = 1'b1;
    run(2, 0, 0, 'h50, 0, 1);
    check("post_rst_sent_count", sent_count, 2);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      run($urandom_range(1, 24), $urandom_range(0, 4), $urandom_range(0, 3),
          $urandom_range(0, 255), $urandom_range(0, 1), 1);
    end

    repeat (3) @(posedge wclk);
    check("leftover_data", exp_data.size(), 0);
    check("leftover_done", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
